// File: rtl/pipelined_addsub_pkg.sv
// Shared types and helpers for the pipelined add/subtract block and its bench.
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Bits per chunk before the remainder is assigned to the last chunk.
  function automatic int chunk_base(input int width, input int stages);
    return (width + stages - 32'sd1) / stages;
  endfunction

  // Width of chunk k; the last chunk takes whatever is left over.
  function automatic int chunk_width(input int width, input int stages, input int k);
    int base;
    base = chunk_base(width, stages);
    if (k < stages - 32'sd1) begin
      return base;
    end else begin
      return width - (stages - 32'sd1) * base;
    end
  endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result stream bundle: master produces operands and consumes results.
interface pipelined_addsub_if #(
  parameter int WIDTH = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_op, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_op, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );
endinterface

// File: rtl/pipelined_addsub_chk.sv
// Elaboration guard: rejects parameter sets that leave the last chunk empty.
module pipelined_addsub_chk
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int STAGES = 3
) ();
  if ((WIDTH < 2) || (STAGES < 1) || (STAGES > WIDTH) ||
      (chunk_width(WIDTH, STAGES, STAGES - 1) <= 0)) begin : g_bad_split
    $error("pipelined_addsub: WIDTH/STAGES split leaves no bits for the last chunk");
  end
endmodule

// File: rtl/pipelined_addsub_chunk.sv
// Combinational N-bit chunk adder: sum, carry out and carry into the MSB.
module addsub_chunk #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o,
  output logic         cmsb_o
);
  logic [N:0] full_s;

  assign full_s = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};
  assign sum_o  = full_s[N-1:0];
  assign cout_o = full_s[N];
  // The MSB sum bit is a ^ b ^ carry-in, so the carry into it falls out directly.
  assign cmsb_o = a_i[N-1] ^ b_i[N-1] ^ full_s[N-1];
endmodule

// File: rtl/pipelined_addsub.sv
// Carry-chained WIDTH-bit add/subtract, one register stage per chunk, with
// a valid/ready stream handshake and signed-overflow / zero flags.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int STAGES = 3
) (
  input logic                clk,
  input logic                rst_n,
  pipelined_addsub_if.slave  bus
);
  localparam int CHUNK = chunk_base(WIDTH, STAGES);

  logic                          adv_s;
  logic [WIDTH-1:0]              b_eff_s;

  // Per-stage inputs (index k = what stage k sees) and results.
  logic [STAGES-1:0][WIDTH-1:0]  a_in_s;
  logic [STAGES-1:0][WIDTH-1:0]  b_in_s;
  logic [STAGES-1:0][WIDTH-1:0]  sum_in_s;
  logic [STAGES-1:0]             cin_s;
  logic [STAGES-1:0]             valid_in_s;
  logic [STAGES-1:0][WIDTH-1:0]  sum_d;
  logic [STAGES-1:0]             carry_d;
  logic [STAGES-1:0]             cmsb_d;

  // Pipeline registers (index k = register after stage k).
  logic [STAGES-1:0][WIDTH-1:0]  a_q;
  logic [STAGES-1:0][WIDTH-1:0]  b_q;
  logic [STAGES-1:0][WIDTH-1:0]  sum_q;
  logic [STAGES-1:0]             carry_q;
  logic [STAGES-1:0]             valid_q;
  logic                          cout_q;
  logic                          ovf_q;
  logic                          zero_q;

  pipelined_addsub_chk #(.WIDTH(WIDTH), .STAGES(STAGES)) u_chk ();

  // The whole pipe moves together; it only freezes when a result is stuck.
  assign adv_s = ~valid_q[STAGES-1] | bus.out_ready;

  // Subtraction is a + ~b + cin, so condition B once at the entry.
  always_comb begin
    if (bus.in_op == OP_SUB) begin
      b_eff_s = ~bus.in_b;
    end else begin
      b_eff_s = bus.in_b;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LSB = k * CHUNK;
    localparam int NW  = chunk_width(WIDTH, STAGES, k);

    logic [NW-1:0]    chunk_sum_s;
    logic [WIDTH-1:0] merged_s;

    if (k == 0) begin : g_first
      assign a_in_s[k]     = bus.in_a;
      assign b_in_s[k]     = b_eff_s;
      assign sum_in_s[k]   = '0;
      assign cin_s[k]      = bus.in_cin;
      assign valid_in_s[k] = bus.in_valid;
    end else begin : g_next
      assign a_in_s[k]     = a_q[k-1];
      assign b_in_s[k]     = b_q[k-1];
      assign sum_in_s[k]   = sum_q[k-1];
      assign cin_s[k]      = carry_q[k-1];
      assign valid_in_s[k] = valid_q[k-1];
    end

    addsub_chunk #(.N(NW)) u_chunk (
      .a_i    (a_in_s[k][LSB +: NW]),
      .b_i    (b_in_s[k][LSB +: NW]),
      .cin_i  (cin_s[k]),
      .sum_o  (chunk_sum_s),
      .cout_o (carry_d[k]),
      .cmsb_o (cmsb_d[k])
    );

    // Lower chunks pass through; this stage fills in its own chunk.
    always_comb begin
      merged_s               = sum_in_s[k];
      merged_s[LSB +: NW]    = chunk_sum_s;
    end

    assign sum_d[k] = merged_s;
  end

  // Stage registers and final flags; everything holds while the output stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      valid_q <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (adv_s) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]     <= a_in_s[k];
        b_q[k]     <= b_in_s[k];
        sum_q[k]   <= sum_d[k];
        carry_q[k] <= carry_d[k];
        valid_q[k] <= valid_in_s[k];
      end
      cout_q <= carry_d[STAGES-1];
      ovf_q  <= carry_d[STAGES-1] ^ cmsb_d[STAGES-1];
      zero_q <= ~|sum_d[STAGES-1];
    end
  end

  assign bus.in_ready  = adv_s;
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.out_sum   = sum_q[STAGES-1];
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_zero  = zero_q;

  // Delayed operand bits below the active chunk and the last stage's carry
  // are intentionally dropped.
  logic unused_ok_s;
  assign unused_ok_s = ^{a_q, b_q, carry_q};
endmodule
